hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//   Consumer of the decoder's RsUsage/RtUsage (Tuse) codes in the P5 5-stage MIPS pipeline.
//   Tracks the destination register and Tnew of the instructions in E, M and W.
//   Produces the D-stage stall plus forwarding selects for D-stage and E-stage operands.
//   Sits beside the pipeline registers. Its internal slots shift in lock-step with the E/M/W registers.
// PARAMETERS
//   REG_AW    5   register-address width
//   TNEW_W    2   width of Tnew counters (max Tnew = 2, load)
// PORTS
//   clk          in   1       system clock, rising edge
//   reset        in   1       synchronous, active-high
//   d_rs         in   REG_AW  rs field of instruction in D
//   d_rt         in   REG_AW  rt field of instruction in D
//   d_rs_usage   in   2       decoder RsUsage: 00 NONE, 01 NOW (Tuse=0), 10 NEXT (Tuse=1); 11 treated as NONE
//   d_rt_usage   in   2       decoder RtUsage, same encoding
//   d_dst        in   REG_AW  final write register of D instr (after RegDst/Link mux); 0 = no write
//   d_tnew       in   TNEW_W  Tnew of D instr measured at E entry: ALU/lui/ori=1, lw=2, jal=0
//   stall        out  1       hold PC and D register, insert bubble into E
//   fwd_rs_d     out  2       D-stage rs source: 00 regfile, 01 E, 10 M, 11 W
//   fwd_rt_d     out  2       D-stage rt source, same encoding
//   fwd_rs_e     out  2       E-stage rs source: 00 E pipeline register value, 01 M, 10 W
//   fwd_rt_e     out  2       E-stage rt source, same encoding
// BEHAVIOUR
//   State: slots E, M, W, each {addr, tnew}. Slot E also holds e_rs and e_rt. addr=0 means empty.
//   Reset (sync): all slot fields 0. All outputs are combinational and therefore 0 immediately after reset.
//   Each posedge when not in reset:
//     - W <= {M.addr, sat_dec(M.tnew)} and M <= {E.addr, sat_dec(E.tnew)}; sat_dec floors at 0.
//     - If stall=0, E <= {d_dst, d_tnew, d_rs, d_rt}.
//     - If stall=1, E <= bubble (all zero). The D inputs are re-presented next cycle.
//   Hazard check per D source s with usage NOW/NEXT (Tuse 0/1):
//     - Find the youngest slot (E > M > W) with addr != 0 and addr == s.
//     - stall if that slot's tnew > Tuse.
//     - Older matching slots never override a younger match.
//   stall = OR over rs/rt hazards. A source with usage NONE never stalls.
//   fwd_*_d:
//     - Select the youngest matching slot only if its tnew == 0.
//     - If the youngest match has tnew > 0 without stalling (Tuse=1 case), select 00; E-stage forwarding covers it.
//     - Source register 0 always selects 00.
//   fwd_*_e:
//     - Compare e_rs/e_rt against M then W. Select the youngest match with addr != 0 and tnew == 0.
//     - A younger M match with tnew > 0 cannot occur by construction; if it does, select 00.
//     - Usage is not checked; forwarding an unused operand is harmless.
//   Stall latency: combinational in the same cycle. Bubble appears in E at the next edge.
//   Simultaneous stall and reset: reset wins, all slots cleared.
//   Reset mid-stall: stall drops the cycle after reset.
// CONFIGURATION
//   HAZARD_STATS_EN defined:
//     - Adds output stall_count [31:0], cleared by reset.
//     - Increments by 1 on every posedge with stall=1 and reset=0; wraps at 2^32 to 0.
//   HAZARD_STATS_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//   1. Reset: hold reset 2 cycles -> stall=0, all fwd=00, stall_count=0.
//   2. lw $1; add $2,$1,$3 (NEXT):
//      - lw in E (tnew 2): stall=1 for exactly 1 cycle.
//      - Next cycle, lw in M (tnew 1): stall=0, fwd_rs_d=00.
//      - add in E, lw in W: fwd_rs_e=10.
//   3. addu $1; beq $1,$1 (NOW):
//      - addu in E (tnew 1): stall=1 for 1 cycle.
//      - Then addu in M (tnew 0): fwd_rs_d=fwd_rt_d=10.
//   4. jal (dst 31, tnew 0); jr $31 -> stall=0, fwd_rs_d=01.
//   5. lw $0; beq $0,$0 -> stall=0, fwd_rs_d=fwd_rt_d=00.
//   6. HAZARD_STATS_EN: two load-use stalls -> stall_count=2; assert reset during a stall -> stall_count=0 and stall=0 the following cycle.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decoder-to-scoreboard bundle: D-stage operand/destination info in, stall and forwarding selects out.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned TNEW_W = 2
);
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [1:0]        d_rs_usage;
    logic [1:0]        d_rt_usage;
    logic [REG_AW-1:0] d_dst;
    logic [TNEW_W-1:0] d_tnew;
    logic              stall;
    logic [1:0]        fwd_rs_d;
    logic [1:0]        fwd_rt_d;
    logic [1:0]        fwd_rs_e;
    logic [1:0]        fwd_rt_e;

    modport master (
        output d_rs, d_rt, d_rs_usage, d_rt_usage, d_dst, d_tnew,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    );

    modport slave (
        input  d_rs, d_rt, d_rs_usage, d_rt_usage, d_dst, d_tnew,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard for the 5-stage MIPS pipeline: D-stage stall plus D/E forwarding selects.
// Optional HAZARD_STATS_EN adds a 32-bit stall_count output.
module hazard_scoreboard #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned TNEW_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_scoreboard_if.slave      bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]             stall_count
`endif
);
    typedef logic [REG_AW-1:0] addr_t;
    typedef logic [TNEW_W-1:0] tnew_t;

    addr_t e_addr_q, e_addr_d, m_addr_q, m_addr_d, w_addr_q, w_addr_d;
    tnew_t e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;
    addr_t e_rs_q, e_rs_d, e_rt_q, e_rt_d;

    logic [1:0] rs_src, rt_src;
    tnew_t      rs_tnew, rt_tnew;
    logic       rs_stall, rt_stall, stall;

    function automatic tnew_t sat_dec(input tnew_t t);
        return (t == '0) ? '0 : t - tnew_t'(1);
    endfunction

    // Youngest matching slot: 0 none, 1 E, 2 M, 3 W (matches the D forwarding code).
    function automatic logic [1:0] youngest(input addr_t s, input addr_t e, input addr_t m,
                                            input addr_t w);
        if (s == '0)      return 2'd0;
        else if (e == s)  return 2'd1;
        else if (m == s)  return 2'd2;
        else if (w == s)  return 2'd3;
        else              return 2'd0;
    endfunction

    function automatic tnew_t slot_tnew(input logic [1:0] src, input tnew_t e, input tnew_t m,
                                        input tnew_t w);
        case (src)
            2'd1:    return e;
            2'd2:    return m;
            2'd3:    return w;
            default: return '0;
        endcase
    endfunction

    // Usage 01 -> Tuse 0, 10 -> Tuse 1, 00/11 never stall.
    function automatic logic hazard(input logic [1:0] usage, input logic [1:0] src, input tnew_t t);
        logic used;
        used = (usage == 2'b01) || (usage == 2'b10);
        return used && (src != 2'd0) && (t > tnew_t'(usage == 2'b10));
    endfunction

    function automatic logic [1:0] fwd_e(input addr_t s, input addr_t m, input tnew_t mt,
                                         input addr_t w, input tnew_t wt);
        if (s != '0 && m == s)                  return (mt == '0) ? 2'b01 : 2'b00;
        else if (s != '0 && w == s && wt == '0) return 2'b10;
        else                                    return 2'b00;
    endfunction

    always_comb begin
        rs_src   = youngest(bus.d_rs, e_addr_q, m_addr_q, w_addr_q);
        rt_src   = youngest(bus.d_rt, e_addr_q, m_addr_q, w_addr_q);
        rs_tnew  = slot_tnew(rs_src, e_tnew_q, m_tnew_q, w_tnew_q);
        rt_tnew  = slot_tnew(rt_src, e_tnew_q, m_tnew_q, w_tnew_q);
        rs_stall = hazard(bus.d_rs_usage, rs_src, rs_tnew);
        rt_stall = hazard(bus.d_rt_usage, rt_src, rt_tnew);
        stall    = rs_stall | rt_stall;

        bus.stall    = stall;
        bus.fwd_rs_d = (rs_src != 2'd0 && rs_tnew == '0) ? rs_src : 2'b00;
        bus.fwd_rt_d = (rt_src != 2'd0 && rt_tnew == '0) ? rt_src : 2'b00;
        bus.fwd_rs_e = fwd_e(e_rs_q, m_addr_q, m_tnew_q, w_addr_q, w_tnew_q);
        bus.fwd_rt_e = fwd_e(e_rt_q, m_addr_q, m_tnew_q, w_addr_q, w_tnew_q);
    end

    always_comb begin
        w_addr_d = m_addr_q;
        w_tnew_d = sat_dec(m_tnew_q);
        m_addr_d = e_addr_q;
        m_tnew_d = sat_dec(e_tnew_q);
        e_addr_d = '0;
        e_tnew_d = '0;
        e_rs_d   = '0;
        e_rt_d   = '0;
        if (!stall) begin
            e_addr_d = bus.d_dst;
            e_tnew_d = bus.d_tnew;
            e_rs_d   = bus.d_rs;
            e_rt_d   = bus.d_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_addr_q <= '0;
            e_tnew_q <= '0;
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            m_addr_q <= '0;
            m_tnew_q <= '0;
            w_addr_q <= '0;
            w_tnew_q <= '0;
        end else begin
            e_addr_q <= e_addr_d;
            e_tnew_q <= e_tnew_d;
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            m_addr_q <= m_addr_d;
            m_tnew_q <= m_tnew_d;
            w_addr_q <= w_addr_d;
            w_tnew_q <= w_tnew_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (reset)      stall_count_q <= '0;
        else if (stall) stall_count_q <= stall_count_q + 32'd1;
    end

    assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus randomized traffic vs a slot-array model.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(5), .TNEW_W(2)) sb ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count;
`endif

    hazard_scoreboard #(.REG_AW(5), .TNEW_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb.slave)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Model state: index 0 = E, 1 = M, 2 = W.
    logic [4:0]  sl_addr [3];
    int          sl_tnew [3];
    logic [4:0]  sl_ers, sl_ert;
    logic [31:0] m_cnt;
    logic        m_stall;
    logic [4:0]  cur_rs, cur_rt, cur_dst;
    logic [1:0]  cur_tnew;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            sl_addr[i] = '0;
            sl_tnew[i] = 0;
        end
        sl_ers = '0;
        sl_ert = '0;
        m_cnt  = '0;
    endtask

    // Presents D inputs, waits to the falling edge and compares every output to the model.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] rsu,
                         input logic [1:0] rtu, input logic [4:0] dst, input logic [1:0] tn);
        logic [1:0] fd [2];
        logic [1:0] fe [2];
        logic [4:0] src;
        logic [1:0] use_c;
        int hit;
        sb.d_rs = rs; sb.d_rt = rt; sb.d_rs_usage = rsu; sb.d_rt_usage = rtu;
        sb.d_dst = dst; sb.d_tnew = tn;
        cur_rs = rs; cur_rt = rt; cur_dst = dst; cur_tnew = tn;
        @(negedge clk);
        m_stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            src   = (k == 0) ? rs : rt;
            use_c = (k == 0) ? rsu : rtu;
            hit = -1;
            for (int i = 0; i < 3; i++)
                if (hit < 0 && src != 0 && sl_addr[i] == src) hit = i;
            fd[k] = 2'b00;
            if (hit >= 0) begin
                if (use_c == 2'b01 && sl_tnew[hit] > 0) m_stall = 1'b1;
                if (use_c == 2'b10 && sl_tnew[hit] > 1) m_stall = 1'b1;
                if (sl_tnew[hit] == 0) fd[k] = 2'(hit + 1);
            end
            src = (k == 0) ? sl_ers : sl_ert;
            hit = -1;
            for (int i = 1; i < 3; i++)
                if (hit < 0 && src != 0 && sl_addr[i] == src) hit = i;
            fe[k] = (hit >= 0 && sl_tnew[hit] == 0) ? 2'(hit) : 2'b00;
        end
        chk("stall", 32'(sb.stall), 32'(m_stall));
        chk("fwd_rs_d", 32'(sb.fwd_rs_d), 32'(fd[0]));
        chk("fwd_rt_d", 32'(sb.fwd_rt_d), 32'(fd[1]));
        chk("fwd_rs_e", 32'(sb.fwd_rs_e), 32'(fe[0]));
        chk("fwd_rt_e", 32'(sb.fwd_rt_e), 32'(fe[1]));
`ifdef HAZARD_STATS_EN
        chk("stall_count", stall_count, m_cnt);
`endif
    endtask

    task automatic advance(input logic rst);
        reset = rst;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (m_stall) m_cnt = m_cnt + 32'd1;
            for (int i = 2; i > 0; i--) begin
                sl_addr[i] = sl_addr[i-1];
                sl_tnew[i] = (sl_tnew[i-1] > 0) ? sl_tnew[i-1] - 1 : 0;
            end
            sl_addr[0] = m_stall ? 5'd0 : cur_dst;
            sl_tnew[0] = m_stall ? 0 : int'(cur_tnew);
            sl_ers     = m_stall ? 5'd0 : cur_rs;
            sl_ert     = m_stall ? 5'd0 : cur_rt;
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            advance(1'b0);
        end
    endtask

    initial begin
        sb.d_rs = '0; sb.d_rt = '0; sb.d_rs_usage = '0; sb.d_rt_usage = '0;
        sb.d_dst = '0; sb.d_tnew = '0;
        model_clear();
        m_stall = 1'b0;
        @(posedge clk);
        #1;
        // Reset held two cycles: everything idle.
        drive(5'd1, 5'd1, 2'b01, 2'b01, 5'd0, 2'd0);
        advance(1'b1);
        drive(5'd1, 5'd1, 2'b01, 2'b01, 5'd0, 2'd0);
        chk("reset_stall", 32'(sb.stall), 0);
        chk("reset_fwd", 32'({sb.fwd_rs_d, sb.fwd_rt_d, sb.fwd_rs_e, sb.fwd_rt_e}), 0);
`ifdef HAZARD_STATS_EN
        chk("reset_count", stall_count, 0);
`endif
        advance(1'b1);

        // lw $1 ; add $2,$1,$3 (NEXT)
        drive(0, 0, 0, 0, 5'd1, 2'd2);
        advance(1'b0);
        drive(5'd1, 5'd3, 2'b10, 2'b10, 5'd2, 2'd1);
        chk("lw_use_stall", 32'(sb.stall), 1);
        advance(1'b0);
        drive(5'd1, 5'd3, 2'b10, 2'b10, 5'd2, 2'd1);
        chk("lw_use_released", 32'(sb.stall), 0);
        chk("lw_use_fwd_rs_d", 32'(sb.fwd_rs_d), 0);
        advance(1'b0);
        drive(0, 0, 0, 0, 0, 0);
        chk("lw_use_fwd_rs_e", 32'(sb.fwd_rs_e), 32'b10);
        advance(1'b0);
        nops(3);

        // addu $1 ; beq $1,$1 (NOW)
        drive(0, 0, 0, 0, 5'd1, 2'd1);
        advance(1'b0);
        drive(5'd1, 5'd1, 2'b01, 2'b01, 5'd0, 2'd0);
        chk("alu_beq_stall", 32'(sb.stall), 1);
        advance(1'b0);
        drive(5'd1, 5'd1, 2'b01, 2'b01, 5'd0, 2'd0);
        chk("alu_beq_released", 32'(sb.stall), 0);
        chk("alu_beq_fwd_rs_d", 32'(sb.fwd_rs_d), 32'b10);
        chk("alu_beq_fwd_rt_d", 32'(sb.fwd_rt_d), 32'b10);
        advance(1'b0);
        nops(3);

        // jal ; jr $31
        drive(0, 0, 0, 0, 5'd31, 2'd0);
        advance(1'b0);
        drive(5'd31, 5'd0, 2'b01, 2'b00, 5'd0, 2'd0);
        chk("jal_jr_stall", 32'(sb.stall), 0);
        chk("jal_jr_fwd_rs_d", 32'(sb.fwd_rs_d), 32'b01);
        advance(1'b0);
        nops(3);

        // lw $0 ; beq $0,$0
        drive(0, 0, 0, 0, 5'd0, 2'd2);
        advance(1'b0);
        drive(5'd0, 5'd0, 2'b01, 2'b01, 5'd0, 2'd0);
        chk("zero_reg_stall", 32'(sb.stall), 0);
        chk("zero_reg_fwd", 32'({sb.fwd_rs_d, sb.fwd_rt_d}), 0);
        advance(1'b0);
        nops(3);

        // Two load-use stalls from a fresh reset, then reset during a stall.
        drive(0, 0, 0, 0, 0, 0);
        advance(1'b1);
        for (int r = 0; r < 2; r++) begin
            drive(0, 0, 0, 0, 5'd4, 2'd2);
            advance(1'b0);
            drive(5'd4, 5'd0, 2'b10, 2'b00, 5'd5, 2'd1);
            advance(1'b0);
            drive(5'd4, 5'd0, 2'b10, 2'b00, 5'd5, 2'd1);
            advance(1'b0);
            nops(3);
        end
        drive(0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
        chk("two_stalls_count", stall_count, 2);
`endif
        advance(1'b0);
        drive(0, 0, 0, 0, 5'd6, 2'd2);
        advance(1'b0);
        drive(5'd6, 5'd6, 2'b01, 2'b10, 5'd7, 2'd1);
        chk("mid_stall_before_reset", 32'(sb.stall), 1);
        advance(1'b1);
        drive(5'd6, 5'd6, 2'b01, 2'b10, 5'd7, 2'd1);
        chk("mid_stall_after_reset", 32'(sb.stall), 0);
`ifdef HAZARD_STATS_EN
        chk("mid_stall_count_cleared", stall_count, 0);
`endif
        advance(1'b0);

        // Randomized traffic over a small register set for dense matches.
        for (int c = 0; c < 600; c++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
            advance(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
